// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - fetch/decode/execute control sequencer driving register-code decoders
// Emits 4-bit bus/load codes plus memory handshake, PC increment, ALU op and halt status.
module micro_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ir_opcode,
  input  logic       z_flag,
  input  logic       mem_ready,
  output logic [3:0] bus_sel,
  output logic [3:0] ld_sel,
  output logic       ld_en,
  output logic [2:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_inc,
  output logic       busy,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam logic [3:0] R_PC   = 4'd0;
  localparam logic [3:0] R_AC   = 4'd2;
  localparam logic [3:0] R_IR   = 4'd3;
  localparam logic [3:0] R_R1   = 4'd4;
  localparam logic [3:0] R_AR   = 4'd7;
  localparam logic [3:0] R_MEM  = 4'd8;
  localparam logic [3:0] R_ALU  = 4'd10;
  localparam logic [3:0] R_ZERO = 4'd11;

  localparam logic [3:0] OP_LDAC = 4'd1;
  localparam logic [3:0] OP_STAC = 4'd2;
  localparam logic [3:0] OP_MVR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JMPZ = 4'd6;
  localparam logic [3:0] OP_END  = 4'd15;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_F1, S_F2, S_DECODE, S_E1, S_E2, S_E3, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic       z_q;
  logic [7:0] cnt_q;
  logic       bus_err_q;

  logic jmp_taken, mem_op, wait_st, timeout;

  assign jmp_taken = (op_q == OP_JMP) || ((op_q == OP_JMPZ) && z_q);
  assign mem_op    = (op_q == OP_LDAC) || (op_q == OP_STAC);
  assign wait_st   = (state_q == S_F2) || (state_q == S_E2) || (state_q == S_E3);
  assign timeout   = wait_st && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_F1;
      S_F1:     state_d = S_F2;
      S_F2: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        if (ir_opcode >= OP_LDAC && ir_opcode <= OP_JMPZ) state_d = S_E1;
        else if (ir_opcode == OP_END)                     state_d = S_HALT;
        else                                              state_d = S_F1;
      end
      S_E1:     state_d = (mem_op || jmp_taken) ? S_E2 : S_F1;
      // E2 is only reached by LDAC/STAC (operand address) or a taken jump
      S_E2: begin
        if (mem_ready)    state_d = jmp_taken ? S_F1 : S_E3;
        else if (timeout) state_d = S_HALT;
      end
      S_E3: begin
        if (mem_ready)    state_d = S_F1;
        else if (timeout) state_d = S_HALT;
      end
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      z_q       <= 1'b0;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= ir_opcode;
        z_q  <= z_flag;
      end
      cnt_q <= (wait_st && !mem_ready && !timeout) ? cnt_q + 8'd1 : 8'd0;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    bus_sel    = R_ZERO;
    ld_sel     = R_ZERO;
    ld_en      = 1'b0;
    alu_op     = 3'b000;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    pc_inc     = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    halted     = (state_q == S_HALT);
    illegal_op = (state_q == S_DECODE) && (ir_opcode >= 4'd7) && (ir_opcode <= 4'd14);
    bus_err    = bus_err_q;
    case (state_q)
      S_F1: begin
        bus_sel = R_PC; ld_sel = R_AR; ld_en = 1'b1;
      end
      S_F2: begin
        mem_rd = 1'b1; bus_sel = R_MEM; ld_sel = R_IR;
        ld_en = mem_ready; pc_inc = mem_ready;
      end
      S_E1: begin
        if (mem_op || jmp_taken) begin
          bus_sel = R_PC; ld_sel = R_AR; ld_en = 1'b1;
        end else if (op_q == OP_MVR) begin
          bus_sel = R_AC; ld_sel = R_R1; ld_en = 1'b1;
        end else if (op_q == OP_ADD) begin
          alu_op = 3'b001; bus_sel = R_ALU; ld_sel = R_AC; ld_en = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      S_E2: begin
        mem_rd = 1'b1; bus_sel = R_MEM; ld_en = mem_ready;
        ld_sel = jmp_taken ? R_PC : R_AR;
        pc_inc = mem_ready && !jmp_taken;
      end
      S_E3: begin
        if (op_q == OP_STAC) begin
          mem_wr = 1'b1; bus_sel = R_AC;
        end else begin
          mem_rd = 1'b1; bus_sel = R_MEM; ld_sel = R_AC; ld_en = mem_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer
// Stimulus queues one expected output vector per cycle; a negedge monitor pops and compares.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ir_opcode = 4'd0;
  logic       z_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] bus_sel, ld_sel;
  logic       ld_en;
  logic [2:0] alu_op;
  logic       mem_rd, mem_wr, pc_inc, busy, halted, illegal_op, bus_err;

  micro_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ir_opcode(ir_opcode), .z_flag(z_flag),
    .mem_ready(mem_ready), .bus_sel(bus_sel), .ld_sel(ld_sel), .ld_en(ld_en),
    .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_inc(pc_inc), .busy(busy),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [18:0] exp_q[$];
  string       nm_q[$];

  function automatic logic [18:0] ev(int bs, int ls, int le, int alu, int rd, int wr,
                                     int inc, int bz, int hl, int il, int er);
    return {4'(bs), 4'(ls), 1'(le), 3'(alu), 1'(rd), 1'(wr), 1'(inc),
            1'(bz), 1'(hl), 1'(il), 1'(er)};
  endfunction

  logic [18:0] got;
  assign got = {bus_sel, ld_sel, ld_en, alu_op, mem_rd, mem_wr, pc_inc,
                busy, halted, illegal_op, bus_err};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got bus=%0d ld=%0d ld_en=%b alu=%b rd=%b wr=%b inc=%b busy=%b halt=%b ill=%b err=%b required %h got %h",
                 n, bus_sel, ld_sel, ld_en, alu_op, mem_rd, mem_wr, pc_inc, busy, halted,
                 illegal_op, bus_err, e, got);
      end
    end
  end

  task automatic cyc(input logic st, input logic [3:0] op, input logic z, input logic rdy,
                     input logic rs, input logic [18:0] e, input string nm);
    @(posedge clk);
    #1;
    start = st; ir_opcode = op; z_flag = z; mem_ready = rdy; rst = rs;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  logic [18:0] v_idle, v_f1, v_f2w, v_f2r, v_dec, v_deci, v_e2arw, v_e2arr;
  logic [18:0] v_e3acw, v_e3acr, v_e3st, v_mvr, v_add, v_jznt, v_e2pc, v_halt, v_halte;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    v_idle  = ev(11, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_f1    = ev( 0,  7, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    v_f2w   = ev( 8,  3, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    v_f2r   = ev( 8,  3, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    v_dec   = ev(11, 11, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v_deci  = ev(11, 11, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v_e2arw = ev( 8,  7, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    v_e2arr = ev( 8,  7, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    v_e3acw = ev( 8,  2, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    v_e3acr = ev( 8,  2, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    v_e3st  = ev( 2, 11, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    v_mvr   = ev( 2,  4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    v_add   = ev(10,  2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    v_jznt  = ev(11, 11, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    v_e2pc  = ev( 8,  0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    v_halt  = ev(11, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v_halte = ev(11, 11, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 1, 0, v_idle,  "reset_state");
    cyc(1, 0, 0, 1, 0, v_idle,  "idle_start");
    // NOP with zero-wait memory
    cyc(0, 0, 0, 1, 0, v_f1,    "nop_f1");
    cyc(0, 0, 0, 1, 0, v_f2r,   "nop_f2");
    cyc(0, 0, 0, 1, 0, v_dec,   "nop_decode");
    // LDAC, every read answered on its second cycle: 9 cycles
    cyc(0, 1, 0, 1, 0, v_f1,    "ldac_f1");
    cyc(0, 1, 0, 0, 0, v_f2w,   "ldac_f2_wait");
    cyc(0, 1, 0, 1, 0, v_f2r,   "ldac_f2_ready");
    cyc(0, 1, 0, 1, 0, v_dec,   "ldac_decode");
    cyc(0, 1, 0, 1, 0, v_f1,    "ldac_e1");
    cyc(0, 1, 0, 0, 0, v_e2arw, "ldac_e2_wait");
    cyc(0, 1, 0, 1, 0, v_e2arr, "ldac_e2_ready");
    cyc(0, 1, 0, 0, 0, v_e3acw, "ldac_e3_wait");
    cyc(0, 1, 0, 1, 0, v_e3acr, "ldac_e3_ready");
    // JMPZ not taken
    cyc(0, 6, 0, 1, 0, v_f1,    "jmpz0_f1");
    cyc(0, 6, 0, 1, 0, v_f2r,   "jmpz0_f2");
    cyc(0, 6, 0, 1, 0, v_dec,   "jmpz0_decode");
    cyc(0, 6, 1, 1, 0, v_jznt,  "jmpz0_e1_skip");
    // JMPZ taken; z changes after DECODE to prove it is latched
    cyc(0, 6, 1, 1, 0, v_f1,    "jmpz1_f1");
    cyc(0, 6, 1, 1, 0, v_f2r,   "jmpz1_f2");
    cyc(0, 6, 1, 1, 0, v_dec,   "jmpz1_decode");
    cyc(0, 6, 0, 1, 0, v_f1,    "jmpz1_e1");
    cyc(0, 6, 0, 1, 0, v_e2pc,  "jmpz1_e2_pc");
    // illegal opcode behaves as NOP
    cyc(0, 9, 0, 1, 0, v_f1,    "ill_f1");
    cyc(0, 9, 0, 1, 0, v_f2r,   "ill_f2");
    cyc(0, 9, 0, 1, 0, v_deci,  "ill_decode");
    // MVR
    cyc(0, 3, 0, 1, 0, v_f1,    "mvr_f1");
    cyc(0, 3, 0, 1, 0, v_f2r,   "mvr_f2");
    cyc(0, 3, 0, 1, 0, v_dec,   "mvr_decode");
    cyc(0, 3, 0, 1, 0, v_mvr,   "mvr_e1");
    // ADD
    cyc(0, 4, 0, 1, 0, v_f1,    "add_f1");
    cyc(0, 4, 0, 1, 0, v_f2r,   "add_f2");
    cyc(0, 4, 0, 1, 0, v_dec,   "add_decode");
    cyc(0, 4, 0, 1, 0, v_add,   "add_e1");
    // STAC with one write wait cycle
    cyc(0, 2, 0, 1, 0, v_f1,    "stac_f1");
    cyc(0, 2, 0, 1, 0, v_f2r,   "stac_f2");
    cyc(0, 2, 0, 1, 0, v_dec,   "stac_decode");
    cyc(0, 2, 0, 1, 0, v_f1,    "stac_e1");
    cyc(0, 2, 0, 1, 0, v_e2arr, "stac_e2");
    cyc(0, 2, 0, 0, 0, v_e3st,  "stac_e3_wait");
    cyc(0, 2, 0, 1, 0, v_e3st,  "stac_e3_ready");
    // END then HALT ignores start
    cyc(0, 15, 0, 1, 0, v_f1,   "end_f1");
    cyc(0, 15, 0, 1, 0, v_f2r,  "end_f2");
    cyc(0, 15, 0, 1, 0, v_dec,  "end_decode");
    cyc(1, 0, 0, 1, 0, v_halt,  "halt_start_ignored");
    cyc(0, 0, 0, 1, 1, v_halt,  "halt_hold");
    cyc(0, 0, 0, 1, 0, v_idle,  "halt_rst_idle");
    // fetch timeout after 4 wait cycles
    cyc(1, 0, 0, 0, 0, v_idle,  "to_start");
    cyc(0, 0, 0, 0, 0, v_f1,    "to_f1");
    cyc(0, 0, 0, 0, 0, v_f2w,   "to_wait1");
    cyc(0, 0, 0, 0, 0, v_f2w,   "to_wait2");
    cyc(0, 0, 0, 0, 0, v_f2w,   "to_wait3");
    cyc(0, 0, 0, 0, 0, v_f2w,   "to_wait4");
    cyc(1, 0, 0, 0, 0, v_halte, "to_halt_err");
    cyc(0, 0, 0, 1, 0, v_halte, "to_err_sticky");
    cyc(0, 0, 0, 1, 1, v_halte, "to_err_before_rst");
    cyc(0, 0, 0, 1, 0, v_idle,  "to_rst_clears");
    // reset during STAC write wait
    cyc(1, 2, 0, 1, 0, v_idle,  "abort_start");
    cyc(0, 2, 0, 1, 0, v_f1,    "abort_f1");
    cyc(0, 2, 0, 1, 0, v_f2r,   "abort_f2");
    cyc(0, 2, 0, 1, 0, v_dec,   "abort_decode");
    cyc(0, 2, 0, 1, 0, v_f1,    "abort_e1");
    cyc(0, 2, 0, 1, 0, v_e2arr, "abort_e2");
    cyc(0, 2, 0, 0, 1, v_e3st,  "abort_e3_rst");
    cyc(0, 2, 0, 1, 0, v_idle,  "abort_idle");
    cyc(0, 2, 0, 1, 0, v_idle,  "abort_stay_idle");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
